// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and the
// multi-beat vector-load freeze, plus a saturating stall-cycle counter.
module hazard_unit #(
    parameter int VLOAD_BEATS = 4,
    parameter int CNT_W       = 32,
    localparam int IDX_W      = $clog2((VLOAD_BEATS > 2) ? VLOAD_BEATS : 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_UsesRs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RegWrite,
    input  logic             EX_VRegWrite,
    input  logic             EX_MemToReg,
    input  logic             EX_BranchTaken,
    input  logic             MEM_VLoad,
    input  logic             mem_valid,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Bubble,
    output logic             beat_we,
    output logic [IDX_W-1:0] beat_idx,
    output logic [CNT_W-1:0] stall_cycles
);

    // state | meaning
    // IDLE  | no vector load in progress; a VLoad entering MEM starts one
    // VLOAD | collecting beats; pipeline frozen until the final beat arrives
    typedef enum logic {IDLE = 1'b0, VLOAD = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VLOAD_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit               ONE_BEAT  = (VLOAD_BEATS == 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic vfreeze;
    logic lu;
    logic lu_stall;
    logic last_beat;

    assign last_beat = mem_valid && (cnt_q == LAST_IDX);

    always_comb begin
        vfreeze = 1'b0;
        if (state_q == IDLE)
            vfreeze = MEM_VLoad && !(ONE_BEAT && mem_valid);
        else
            vfreeze = !last_beat;
    end

    // A write to x0 is harmless unless it targets the vector file.
    assign lu = EX_MemToReg && (EX_RegWrite || EX_VRegWrite)
             && ((EX_rd == ID_rs1) || ((EX_rd == ID_rs2) && ID_UsesRs2))
             && !((EX_rd == 5'd0) && !EX_VRegWrite);

    assign lu_stall = lu && !vfreeze && !EX_BranchTaken;

    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        if (vfreeze) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (lu_stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    assign beat_we      = mem_valid && ((state_q == VLOAD) || ((state_q == IDLE) && MEM_VLoad));
    assign beat_idx     = cnt_q;
    assign stall_cycles = stall_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (vfreeze) begin
                state_d = VLOAD;
                cnt_d   = mem_valid ? IDX_W'(1) : '0;
            end
        end else if (mem_valid) begin
            if (cnt_q == LAST_IDX) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((vfreeze || lu_stall) && (stall_q != CNT_MAX))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every output each cycle.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd;
    logic        ID_UsesRs2, EX_RegWrite, EX_VRegWrite, EX_MemToReg;
    logic        EX_BranchTaken, MEM_VLoad, mem_valid;
    logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic        IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, beat_we;
    logic [1:0]  beat_idx;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_unit #(.VLOAD_BEATS(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_UsesRs2(ID_UsesRs2),
        .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .EX_VRegWrite(EX_VRegWrite),
        .EX_MemToReg(EX_MemToReg), .EX_BranchTaken(EX_BranchTaken),
        .MEM_VLoad(MEM_VLoad), .mem_valid(mem_valid),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .MEM_WB_Bubble(MEM_WB_Bubble),
        .beat_we(beat_we), .beat_idx(beat_idx), .stall_cycles(stall_cycles)
    );

    // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    //  IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, beat_we}
    localparam logic [7:0] DEF    = 8'b1111_0000;
    localparam logic [7:0] LU     = 8'b0011_0100;
    localparam logic [7:0] BR     = 8'b1111_1100;
    localparam logic [7:0] FRZ    = 8'b0000_0010;
    localparam logic [7:0] FRZ_WE = 8'b0000_0011;
    localparam logic [7:0] REL    = 8'b1111_0001;
    localparam logic [7:0] REL_BR = 8'b1111_1101;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [1:0]  idx;
        logic [31:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   done    = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                   IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, beat_we};
            n_total++;
            if (act === e.ctl && beat_idx === e.idx && stall_cycles === e.stall)
                n_pass++;
            else
                $display("FAIL %s: ctl=%b want %b, beat_idx=%0d want %0d, stall_cycles=%0d want %0d",
                         e.name, act, e.ctl, beat_idx, e.idx, stall_cycles, e.stall);
        end
    end

    task automatic clear_in();
        ID_rs1 = 5'd1; ID_rs2 = 5'd2; ID_UsesRs2 = 1'b0;
        EX_rd = 5'd9; EX_RegWrite = 1'b0; EX_VRegWrite = 1'b0; EX_MemToReg = 1'b0;
        EX_BranchTaken = 1'b0; MEM_VLoad = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic load_ex(input logic [4:0] rd);
        EX_rd = rd; EX_MemToReg = 1'b1; EX_RegWrite = 1'b1;
    endtask

    task automatic cyc(input string name, input logic [7:0] ctl,
                       input logic [1:0] idx, input logic [31:0] stall);
        exp_t e;
        e.name = name; e.ctl = ctl; e.idx = idx; e.stall = stall;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic cyc_nochk();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: run still active, want finished");
            $fatal(1, "timeout");
        end
    end

    initial begin
        clear_in();
        rst = 1'b1;
        cyc_nochk();
        cyc_nochk();
        rst = 1'b0;

        cyc("reset_default", DEF, 2'd0, 32'd0);

        load_ex(5'd5); ID_rs1 = 5'd5;
        cyc("lu_rs1", LU, 2'd0, 32'd0);
        clear_in();
        cyc("lu_bubble_clears", DEF, 2'd0, 32'd1);

        load_ex(5'd7); ID_rs1 = 5'd3; ID_rs2 = 5'd7; ID_UsesRs2 = 1'b0;
        cyc("rs2_unused", DEF, 2'd0, 32'd1);
        ID_UsesRs2 = 1'b1;
        cyc("lu_rs2", LU, 2'd0, 32'd1);

        clear_in(); load_ex(5'd0); ID_rs1 = 5'd0;
        cyc("x0_excluded", DEF, 2'd0, 32'd2);
        EX_VRegWrite = 1'b1;
        cyc("x0_vreg_stalls", LU, 2'd0, 32'd2);

        clear_in(); EX_rd = 5'd5; ID_rs1 = 5'd5; EX_MemToReg = 1'b1;
        cyc("no_write_no_lu", DEF, 2'd0, 32'd3);

        clear_in(); EX_BranchTaken = 1'b1;
        cyc("branch", BR, 2'd0, 32'd3);
        load_ex(5'd5); ID_rs1 = 5'd5;
        cyc("branch_beats_lu", BR, 2'd0, 32'd3);

        clear_in(); MEM_VLoad = 1'b1; mem_valid = 1'b1;
        cyc("vl4_beat0", FRZ_WE, 2'd0, 32'd3);
        MEM_VLoad = 1'b0;
        cyc("vl4_beat1", FRZ_WE, 2'd1, 32'd4);
        cyc("vl4_beat2", FRZ_WE, 2'd2, 32'd5);
        cyc("vl4_release", REL, 2'd3, 32'd6);
        mem_valid = 1'b0;
        cyc("vl4_after", DEF, 2'd0, 32'd6);

        // Pattern 1,0,1,0,1,1 with a load-use hazard held during the freeze.
        load_ex(5'd5); ID_rs1 = 5'd5; MEM_VLoad = 1'b1; mem_valid = 1'b1;
        cyc("gap_c0", FRZ_WE, 2'd0, 32'd6);
        MEM_VLoad = 1'b0; mem_valid = 1'b0;
        cyc("gap_c1", FRZ, 2'd1, 32'd7);
        mem_valid = 1'b1;
        cyc("gap_c2", FRZ_WE, 2'd1, 32'd8);
        mem_valid = 1'b0;
        cyc("gap_c3", FRZ, 2'd2, 32'd9);
        mem_valid = 1'b1;
        cyc("gap_c4", FRZ_WE, 2'd2, 32'd10);
        clear_in(); mem_valid = 1'b1;
        cyc("gap_release", REL, 2'd3, 32'd11);
        mem_valid = 1'b0;
        cyc("gap_after", DEF, 2'd0, 32'd11);

        EX_BranchTaken = 1'b1; MEM_VLoad = 1'b1; mem_valid = 1'b1;
        cyc("br_frz_c0", FRZ_WE, 2'd0, 32'd11);
        MEM_VLoad = 1'b0;
        cyc("br_frz_c1", FRZ_WE, 2'd1, 32'd12);
        cyc("br_frz_c2", FRZ_WE, 2'd2, 32'd13);
        cyc("br_release_flush", REL_BR, 2'd3, 32'd14);

        EX_BranchTaken = 1'b0; MEM_VLoad = 1'b1;
        cyc("b2b_retrigger", FRZ_WE, 2'd0, 32'd14);
        MEM_VLoad = 1'b0;
        cyc("b2b_beat1", FRZ_WE, 2'd1, 32'd15);
        mem_valid = 1'b0; rst = 1'b1;
        cyc_nochk();
        rst = 1'b0; mem_valid = 1'b1;
        cyc("post_reset", DEF, 2'd0, 32'd0);
        mem_valid = 1'b0;
        cyc("post_reset_idle", DEF, 2'd0, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that produces the stall, flush and bubble controls the forwarding path cannot resolve. It covers scalar/vector load-use stalls, taken-branch flushes, and multi-beat 128-bit vector loads that freeze the pipeline while MEM collects beats. It sits beside the forwarding unit. It observes ID, EX and MEM stage fields and drives the write-enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- VLOAD_BEATS, 4: memory beats per vector load (≥1).
- CNT_W, 32: width of the stall-cycle counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_UsesRs2  in  1  the ID instruction reads rs2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_RegWrite, EX_VRegWrite, EX_MemToReg  in  1 each  write controls of the instruction in EX.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- MEM_VLoad  in  1  the instruction in MEM is a vector load.
- mem_valid  in  1  data memory presents one beat this cycle.
- PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  stage register enables.
- IF_ID_Flush, ID_EX_Flush  out  1 each  zero the control fields of that register on the edge.
- MEM_WB_Bubble  out  1  MEM/WB captures a no-op.
- beat_we  out  1  write the current beat into the vector load buffer.
- beat_idx  out  $clog2(max(VLOAD_BEATS,2))  index of the current beat.
- stall_cycles  out  CNT_W  saturating count of frozen or stalled cycles.

## Operation
- FSM states: IDLE and VLOAD. There is a beat counter `cnt` with range 0..VLOAD_BEATS-1.
- vfreeze is asserted in either of two cases:
  - state IDLE with MEM_VLoad=1, except when VLOAD_BEATS=1 and mem_valid=1;
  - state VLOAD, except when mem_valid=1 and cnt=VLOAD_BEATS-1.
- When vfreeze=1, the following hold:
  - PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0.
  - MEM_WB_Bubble is 1.
  - Both flush outputs are 0.
  - Load-use detection is suppressed.
- Beat capture: beat_we = mem_valid & (VLOAD | (IDLE & MEM_VLoad)). beat_idx equals cnt.
- Transitions:
  - IDLE→VLOAD when vfreeze=1. On that edge, cnt becomes 1 if mem_valid=1, else 0.
  - In VLOAD, each mem_valid increments cnt.
  - The final beat (mem_valid=1, cnt=VLOAD_BEATS-1) releases the freeze in that same cycle. The next state is IDLE and cnt is cleared.
- Load-use (lu) is raised when all of the following hold:
  - EX_MemToReg=1 and (EX_RegWrite or EX_VRegWrite) is 1;
  - EX_rd equals ID_rs1, or EX_rd equals ID_rs2 with ID_UsesRs2=1;
  - the pair is not the excluded case EX_rd=0 with EX_VRegWrite=0.
- Response to lu=1 (no freeze, no branch): PCWrite=0, IF_ID_Write=0 and ID_EX_Flush=1, which inserts one bubble.
- Response to a taken branch (no freeze): IF_ID_Flush=1 and ID_EX_Flush=1. All enables stay 1.
- Priority order: vfreeze > branch > load-use.
  - Branch together with lu: the branch wins and there is no stall.
  - Branch during a freeze: the branch is held in EX and flushes on the release cycle.
- Default outputs: all enables 1, flushes 0, MEM_WB_Bubble 0.
- stall_cycles increments on every edge where (vfreeze or lu-stall) is true. It saturates at all-ones.

## Timing
- Detection is combinational in the same cycle. Control outputs take effect on the next rising edge.
- Vector load freeze length: with k idle cycles between beats, the freeze lasts VLOAD_BEATS-1+k cycles from MEM entry. The release coincides with the last beat.
- Back-to-back vector loads: the second load reaches MEM on the cycle after release. It retriggers from IDLE with no gap.
- Load-use costs exactly 1 bubble. The condition clears on the next cycle because EX then holds the bubble.
- Reset (rst=1 on an edge) has these effects:
  - state becomes IDLE, cnt becomes 0, stall_cycles becomes 0;
  - the cycle after reset shows default outputs, beat_we=0 and beat_idx=0 (provided MEM_VLoad=0).
- Reset in the middle of a vector load aborts it, with no residual freeze. Reset has priority over counter increment.

## Test plan
- Load-use: EX holds lw x5 (MemToReg=1, RegWrite=1, rd=5) and ID holds add using rs1=5. Required: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 1 cycle; stall_cycles goes from 0 to 1.
- x0 exclusion: EX_rd=0, RegWrite=1, MemToReg=1, VRegWrite=0, ID_rs1=0. Required: no stall. With VRegWrite=1 and ID_rs1=0, the stall is required.
- Vector load with VLOAD_BEATS=4 and mem_valid high continuously. Required:
  - freeze for exactly 3 cycles, released on the 4th;
  - beat_idx sequence 0,1,2,3, with beat_we=1 on each of those 4 cycles;
  - stall_cycles=3.
- Vector load with mem_valid pattern 1,0,1,0,1,1. Required:
  - freeze lasts 5 cycles;
  - beat_we=1 only on the valid cycles;
  - release on the 6th cycle.
- Taken branch during freeze: EX_BranchTaken=1 throughout a vector load. Required: no flush while frozen; IF_ID_Flush=1 and ID_EX_Flush=1 on the release cycle only.
- Mid-freeze reset: after 2 beats, assert rst for one edge. Required: state IDLE, default outputs, beat_idx=0, stall_cycles=0 on the next cycle.
